branch_target_buffer: RTL and testbench

Parametrised direct-mapped branch target buffer (BTB) with a per-entry 2-bit saturating direction predictor, sitting beside the fetch stage. A combinational lookup on the fetch PC returns a hit flag, a predicted direction and a next-fetch address. Resolved branches from execute update the tag/target array and the pattern history table (PHT) on the clock edge. An optional gshare mode XORs a global history register into the PHT index.

---
 rtl/branch_target_buffer_if.sv | 37 +++
 rtl/branch_target_buffer.sv | 114 +++++++++++
 tb/tb_branch_target_buffer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/branch_target_buffer_if.sv
// Fetch/execute-side bundle for the branch target buffer.
// The master drives the fetch PC and resolved-branch updates and receives the prediction.
// The slave (the BTB) does the reverse.
interface branch_target_buffer_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] lookup_pc;
    logic              predict_hit;
    logic              predict_taken;
    logic [ADDR_W-1:0] predict_target;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_pc;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;

    modport master (
        output lookup_pc,
        output upd_valid,
        output upd_pc,
        output upd_taken,
        output upd_target,
        input  predict_hit,
        input  predict_taken,
        input  predict_target
    );

    modport slave (
        input  lookup_pc,
        input  upd_valid,
        input  upd_pc,
        input  upd_taken,
        input  upd_target,
        output predict_hit,
        output predict_taken,
        output predict_target
    );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with a 2-bit saturating direction counter per PHT entry.
// Lookup is combinational on the fetch PC. Resolved branches update the tables on the rising edge.
// Optional feature: define BRANCH_TARGET_BUFFER_GSHARE_EN to XOR a global history
// register into the PHT index (gshare). With the macro undefined, the PHT is indexed like the BTB.
module branch_target_buffer #(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = 32
) (
    input  logic                         CLK,
    input  logic                         nRST,
    branch_target_buffer_if.slave        bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    // Flattened views of the per-entry state, so lookup and update can index by PC.
    logic [ENTRIES-1:0] valid_all;
    logic [TAG_W-1:0]   tag_all    [ENTRIES];
    logic [ADDR_W-1:0]  target_all [ENTRIES];
    logic [1:0]         pht_all    [ENTRIES];

    // PC field extraction; bits [1:0] are ignored because PCs are word-aligned.
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic [IDX_W-1:0] lk_pidx;
    logic [IDX_W-1:0] up_pidx;
    logic             unused_pc_bits;

    assign lk_idx = bus.lookup_pc[IDX_W+1:2];
    assign lk_tag = bus.lookup_pc[ADDR_W-1:IDX_W+2];
    assign up_idx = bus.upd_pc[IDX_W+1:2];
    assign up_tag = bus.upd_pc[ADDR_W-1:IDX_W+2];
    assign unused_pc_bits = ^{bus.lookup_pc[1:0], bus.upd_pc[1:0]};

`ifdef BRANCH_TARGET_BUFFER_GSHARE_EN
    // Non-speculative global history: shifted only when a branch resolves.
    logic [IDX_W-1:0] ghr_reg;
    logic [IDX_W-1:0] ghr_next;

    if (IDX_W > 1) begin : g_ghr_shift
        assign ghr_next = {ghr_reg[IDX_W-2:0], bus.upd_taken};
    end else begin : g_ghr_bit
        assign ghr_next = bus.upd_taken;
    end

    // History register; the PHT update on the same edge still sees the pre-shift value.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ghr_reg <= '0;
        end else if (bus.upd_valid) begin
            ghr_reg <= ghr_next;
        end
    end

    assign lk_pidx = lk_idx ^ ghr_reg;
    assign up_pidx = up_idx ^ ghr_reg;
`else
    assign lk_pidx = lk_idx;
    assign up_pidx = up_idx;
`endif

    // Per-entry storage. Every taken resolution writes its entry: on a hit this refreshes the
    // target (the tag already matches), on a miss it allocates over whatever was aliasing there.
    // Not-taken resolutions never touch tag/target, so no separate hit detection is needed here.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic              valid_reg;
            logic [TAG_W-1:0]  tag_reg;
            logic [ADDR_W-1:0] target_reg;
            logic [1:0]        pht_reg;

            // Tag/target allocation and refresh on taken branches mapping to this entry.
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    valid_reg  <= 1'b0;
                    tag_reg    <= '0;
                    target_reg <= '0;
                end else if (bus.upd_valid && bus.upd_taken && (up_idx == IDX_W'(gi))) begin
                    valid_reg  <= 1'b1;
                    tag_reg    <= up_tag;
                    target_reg <= bus.upd_target;
                end
            end

            // Saturating direction counter, trained on every resolution regardless of hit.
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    pht_reg <= 2'b00;
                end else if (bus.upd_valid && (up_pidx == IDX_W'(gi))) begin
                    if (bus.upd_taken && (pht_reg != 2'b11)) begin
                        pht_reg <= pht_reg + 2'd1;
                    end else if (!bus.upd_taken && (pht_reg != 2'b00)) begin
                        pht_reg <= pht_reg - 2'd1;
                    end
                end
            end

            assign valid_all[gi]  = valid_reg;
            assign tag_all[gi]    = tag_reg;
            assign target_all[gi] = target_reg;
            assign pht_all[gi]    = pht_reg;
        end
    endgenerate

    // Zero-latency lookup; same-cycle updates are not bypassed, so this reads pre-edge state.
    always_comb begin
        bus.predict_hit    = valid_all[lk_idx] && (tag_all[lk_idx] == lk_tag);
        bus.predict_taken  = bus.predict_hit && pht_all[lk_pidx][1];
        bus.predict_target = bus.predict_taken ? target_all[lk_idx]
                                               : bus.lookup_pc + ADDR_W'(4);
    end
endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed testbench for branch_target_buffer (ENTRIES=16, ADDR_W=32).
// Expectations differ between builds only where the PHT index depends on history;
// define BRANCH_TARGET_BUFFER_GSHARE_EN here too when building the gshare variant.
module tb_branch_target_buffer;
    logic CLK;
    logic nRST;
    int   tests_run;
    int   tests_failed;
    logic [31:0] live_pc;

    branch_target_buffer_if #(.ADDR_W(32)) bus ();

    branch_target_buffer #(
        .ENTRIES(16),
        .ADDR_W (32)
    ) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end else begin
            $display("[TB] ok   %s: 0x%08h", tag, obs);
        end
    endtask

    // Apply a lookup PC and check all three prediction outputs (called away from the edge).
    task automatic lookup_chk(input string tag, input logic [31:0] pc,
                              input logic h, input logic t, input logic [31:0] tgt);
        bus.lookup_pc = pc;
        #1;
        check({tag, ".hit"},    32'(bus.predict_hit),   32'(h));
        check({tag, ".taken"},  32'(bus.predict_taken), 32'(t));
        check({tag, ".target"}, bus.predict_target,     tgt);
    endtask

    // Present one resolved branch for exactly one rising edge; returns at the next negedge.
    task automatic update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = pc;
        bus.upd_taken  = tk;
        bus.upd_target = tgt;
        @(negedge CLK);
        bus.upd_valid  = 1'b0;
    endtask

    initial begin
        tests_run        = 0;
        tests_failed     = 0;
        nRST             = 1'b0;
        bus.lookup_pc    = '0;
        bus.upd_valid    = 1'b0;
        bus.upd_pc       = '0;
        bus.upd_taken    = 1'b0;
        bus.upd_target   = '0;

        // Reset state
        @(negedge CLK);
        lookup_chk("rst", 32'h100, 1'b0, 1'b0, 32'h104);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);

        // First taken update: counter 00->01, entry allocated, not yet predicted taken
        update(32'h100, 1'b1, 32'h200);
        lookup_chk("alloc1", 32'h100, 1'b1, 1'b0, 32'h104);

        // Second taken update with lookup in the same cycle: old contents visible before the edge
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = 32'h100;
        bus.upd_taken  = 1'b1;
        bus.upd_target = 32'h200;
        lookup_chk("same_cyc", 32'h100, 1'b1, 1'b0, 32'h104);
        @(negedge CLK);
        bus.upd_valid = 1'b0;
`ifdef BRANCH_TARGET_BUFFER_GSHARE_EN
        // ghr 0->1->3; updates trained PHT[0] and PHT[1]; lookup reads PHT[3]=00
        lookup_chk("gshare2", 32'h100, 1'b1, 1'b0, 32'h104);
        live_pc = 32'h100;
`else
        // PHT[0] now 10
        lookup_chk("taken2", 32'h100, 1'b1, 1'b1, 32'h200);

        // Hysteresis: third taken -> 11; not-taken (junk target) -> 10, target kept
        update(32'h100, 1'b1, 32'h200);
        update(32'h100, 1'b0, 32'h5550);
        lookup_chk("hyst_nt1", 32'h100, 1'b1, 1'b1, 32'h200);
        update(32'h100, 1'b0, 32'h5550);
        lookup_chk("hyst_nt2", 32'h100, 1'b1, 1'b0, 32'h104);

        // Hit and taken overwrites target: 01 -> 10
        update(32'h100, 1'b1, 32'h280);
        lookup_chk("retarget", 32'h100, 1'b1, 1'b1, 32'h280);

        // Miss and not taken: no allocation
        update(32'h208, 1'b0, 32'h400);
        lookup_chk("no_alloc", 32'h208, 1'b0, 1'b0, 32'h20C);

        // Aliasing: 0x140 shares index 0 with 0x100
        lookup_chk("alias_miss", 32'h140, 1'b0, 1'b0, 32'h144);
        update(32'h140, 1'b1, 32'h300);
        lookup_chk("alias_new", 32'h140, 1'b1, 1'b1, 32'h300);
        lookup_chk("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
        live_pc = 32'h140;
`endif

        // Wrap-around of the fall-through address on a miss
        lookup_chk("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);

        // Mid-run asynchronous reset: outputs clear in the same cycle
        bus.lookup_pc = live_pc;
        #1;
        check("pre_rst.hit", 32'(bus.predict_hit), 32'd1);
        nRST = 1'b0;
        lookup_chk("mid_rst", live_pc, 1'b0, 1'b0, live_pc + 32'd4);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        lookup_chk("post_rst", live_pc, 1'b0, 1'b0, live_pc + 32'd4);

        // Counters were cleared: one taken update only reaches 01
        update(live_pc, 1'b1, 32'h600);
        lookup_chk("pht_clr", live_pc, 1'b1, 1'b0, live_pc + 32'd4);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
